// File: rtl/sobel_edge.sv
// rtl/sobel_edge.sv - streaming 3x3 Sobel edge detector, |Gx|+|Gy| saturated to DATA_W bits
module sobel_edge #(
    parameter int ROW_LENGTH = 640,
    parameter int DATA_W     = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    input  logic              i_sof,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid
);

    localparam int COL_W = $clog2(ROW_LENGTH);

    logic              accept;
    logic [COL_W-1:0]  col_q, col_d, col_cur;
    logic [1:0]        row_q, row_d, row_cur;

    logic [DATA_W-1:0] lb1_q [ROW_LENGTH];
    logic [DATA_W-1:0] lb2_q [ROW_LENGTH];
    logic [DATA_W-1:0] up_pix, upup_pix;

    logic [DATA_W-1:0] w_q [3][3];
    logic [DATA_W-1:0] w_d [3][3];

    logic              s1_valid_q, s1_valid_d;
    logic              o_valid_q, o_valid_d;
    logic [DATA_W-1:0] o_data_q, o_data_d;

    logic signed [15:0] p [3][3];
    logic signed [15:0] gx, gy;
    logic        [15:0] abs_gx, abs_gy, mag;
    logic [DATA_W-1:0]  mag_sat;

    always_comb begin
        accept  = i_valid && !i_rst;
        // A start-of-frame pixel is placed at (0,0) regardless of where the counters were
        col_cur = i_sof ? '0 : col_q;
        row_cur = i_sof ? 2'd0 : row_q;

        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (col_cur == COL_W'(ROW_LENGTH - 1)) begin
                col_d = '0;
                row_d = (row_cur == 2'd2) ? 2'd2 : row_cur + 2'd1;
            end else begin
                col_d = col_cur + COL_W'(1);
                row_d = row_cur;
            end
        end

        up_pix   = lb1_q[col_cur];
        upup_pix = lb2_q[col_cur];

        w_d = w_q;
        if (accept) begin
            for (int y = 0; y < 3; y++) begin
                for (int x = 0; x < 2; x++) begin
                    w_d[y][x] = w_q[y][x+1];
                end
            end
            w_d[0][2] = upup_pix;
            w_d[1][2] = up_pix;
            w_d[2][2] = i_data;
        end

        s1_valid_d = accept && (row_cur == 2'd2) && (col_cur >= COL_W'(2));
    end

    always_comb begin
        for (int y = 0; y < 3; y++) begin
            for (int x = 0; x < 3; x++) begin
                p[y][x] = signed'(16'(w_q[y][x]));
            end
        end
        gx = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
        gy = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
        abs_gx  = gx[15] ? 16'(-gx) : 16'(gx);
        abs_gy  = gy[15] ? 16'(-gy) : 16'(gy);
        mag     = abs_gx + abs_gy;
        mag_sat = (mag > 16'((1 << DATA_W) - 1)) ? '1 : mag[DATA_W-1:0];

        o_valid_d = s1_valid_q;
        o_data_d  = s1_valid_q ? mag_sat : o_data_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            col_q      <= '0;
            row_q      <= 2'd0;
            s1_valid_q <= 1'b0;
            o_valid_q  <= 1'b0;
            o_data_q   <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            s1_valid_q <= s1_valid_d;
            o_valid_q  <= o_valid_d;
            o_data_q   <= o_data_d;
        end
        w_q <= w_d;
    end

    // Row r-1 moves down into the r-2 line as the current row overwrites it
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb1_q[col_cur] <= i_data;
            lb2_q[col_cur] <= lb1_q[col_cur];
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;

endmodule
